mac_seq: RTL and testbench

- Sequencer/accumulator that streams VEC_LEN (m, x) operand pairs into the team's combinational fixed-point MAC stage (y = m*x + b).
- Feeds the MAC's b input from its own accumulator register and captures the MAC's y output, producing one dot product plus bias per vector.
- Sits directly upstream of, and consumes the result of, the MAC stage in the reservoir/dense-layer datapath.
- Owns all sequencing: handshakes, element counting and result hold.

---
 rtl/mac_seq.sv | 134 +++++++++++++
 tb/tb_mac_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// mac_seq: streams VEC_LEN (m, x) pairs into an external combinational MAC (y = m*x + b),
//   feeding b from its own accumulator and capturing y, giving one dot product plus bias per vector.
// Latency: out_valid rises the cycle after the last accepted beat; at best VEC_LEN+1 cycles per vector.
// Backpressure: in_ready drops while a result is held; the result holds until out_ready.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   in_valid/in_ready       operand-pair handshake; in_m, in_x operands, in_bias used on first beat only
//   mac_m/mac_x/mac_b       operands driven to the MAC stage
//   mac_y                   MAC result, combinational from mac_m/mac_x/mac_b in the same cycle
//   out_valid/out_ready     result handshake; out_y holds the dot product plus bias
//   busy                    high while a vector is in progress or its result is held
module mac_seq #(
    parameter int VEC_LEN = 16,
    parameter int IW_M    = 4,
    parameter int QW_M    = 8,
    parameter int IW_X    = 4,
    parameter int QW_X    = 8,
    parameter int IW_Y    = 4,
    parameter int QW_Y    = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IW_M+QW_M-1:0]   in_m,
    input  logic [IW_X+QW_X-1:0]   in_x,
    input  logic [IW_Y+QW_Y-1:0]   in_bias,
    output logic [IW_M+QW_M-1:0]   mac_m,
    output logic [IW_X+QW_X-1:0]   mac_x,
    output logic [IW_Y+QW_Y-1:0]   mac_b,
    input  logic [IW_Y+QW_Y-1:0]   mac_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IW_Y+QW_Y-1:0]   out_y,
    output logic                   busy
);

    localparam int WY = IW_Y + QW_Y;
    localparam int CW = $clog2(VEC_LEN + 1);
    // Count value seen on the beat that completes the vector.
    localparam logic [CW-1:0] LAST_CNT = CW'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WY-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            beat;

    // Operands pass straight through; the MAC is purely combinational.
    assign mac_m = in_m;
    assign mac_x = in_x;
    assign out_y = acc_q;
    assign beat  = in_valid && in_ready;

    // State and datapath registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and accumulator update. acc takes mac_y bit-for-bit: any
    // rounding or wrap has already happened inside the MAC.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    acc_d   = mac_y;
                    cnt_d   = CW'(1);
                    state_d = (VEC_LEN == 1) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_d = mac_y;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs. The first beat of a vector adds the bias by presenting it on
    // mac_b; later beats chain the running sum back in.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        mac_b     = acc_q;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                mac_b    = in_bias;
            end
            S_ACCUM: begin
                in_ready = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: table-driven bench for mac_seq with a behavioural Q4.8 MAC (truncate/wrap)
//   wired to each DUT, and a scoreboard queue of expected results popped on each handshake.
// Two builds: VEC_LEN=4 for the main table, VEC_LEN=1 for the single-beat case.
module tb_mac_seq;

    localparam int W = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // VEC_LEN=4 instance
    logic                in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic signed [W-1:0] in_m_a, in_x_a, in_bias_a, mac_m_a, mac_x_a, mac_b_a, mac_y_a, out_y_a;

    // VEC_LEN=1 instance
    logic                in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic signed [W-1:0] in_m_b, in_x_b, in_bias_b, mac_m_b, mac_x_b, mac_b_b, mac_y_b, out_y_b;

    int errors = 0;
    int checks = 0;
    logic signed [W-1:0] exp_q[$];

    // y = m*x + b: product Q8.16 loses its 8 lowest bits, sum wraps to 12 bits.
    function automatic logic signed [W-1:0] mac_f(input logic signed [W-1:0] m,
                                                  input logic signed [W-1:0] x,
                                                  input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        logic signed [W-1:0]   t;
        p = m * x;
        t = p[W+7:8];
        return t + b;
    endfunction

    assign mac_y_a = mac_f(mac_m_a, mac_x_a, mac_b_a);
    assign mac_y_b = mac_f(mac_m_b, mac_x_b, mac_b_b);

    mac_seq #(.VEC_LEN(4)) dut_a (
        .clk_in(clk), .rst_in(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_m(in_m_a), .in_x(in_x_a), .in_bias(in_bias_a),
        .mac_m(mac_m_a), .mac_x(mac_x_a), .mac_b(mac_b_a), .mac_y(mac_y_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_y(out_y_a),
        .busy(busy_a)
    );

    mac_seq #(.VEC_LEN(1)) dut_b (
        .clk_in(clk), .rst_in(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_m(in_m_b), .in_x(in_x_b), .in_bias(in_bias_b),
        .mac_m(mac_m_b), .mac_x(mac_x_b), .mac_b(mac_b_b), .mac_y(mac_y_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_y(out_y_b),
        .busy(busy_b)
    );

    typedef struct {
        string               name;
        logic [3:0][W-1:0]   m;
        logic [3:0][W-1:0]   x;
        logic signed [W-1:0] bias;
        int                  gap;          // idle cycles between beats
        int                  hold;         // cycles out_ready stays low
        int                  abort_beats;  // beats of a vector abandoned by reset beforehand
        logic signed [W-1:0] exp_y;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Partial vector, then reset: nothing of it may survive.
    task automatic abort_vec(input string name, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            in_valid_a = 1'b1;
            in_m_a     = 12'h100;
            in_x_a     = 12'h100;
            in_bias_a  = 12'h123;
            @(negedge clk);
        end
        in_valid_a = 1'b0;
        chk({name, " pre-reset busy"}, busy_a, 1);
        rst = 1'b1;
        @(negedge clk);
        chk({name, " reset busy"}, busy_a, 0);
        chk({name, " reset out_valid"}, out_valid_a, 0);
        chk({name, " reset in_ready"}, in_ready_a, 1);
        chk({name, " reset out_y"}, out_y_a, 0);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic signed [W-1:0] acc;
        logic signed [W-1:0] held;
        logic signed [W-1:0] exp_y;
        if (v.abort_beats > 0) abort_vec(v.name, v.abort_beats);
        chk({v.name, " idle in_ready"}, in_ready_a, 1);
        chk({v.name, " idle busy"}, busy_a, 0);
        acc = v.bias;
        exp_q.push_back(v.exp_y);
        for (int i = 0; i < 4; i++) begin
            in_valid_a = 1'b1;
            in_m_a     = v.m[i];
            in_x_a     = v.x[i];
            in_bias_a  = (i == 0) ? v.bias : W'($urandom);
            #1;
            chk($sformatf("%s beat%0d mac_b", v.name, i), mac_b_a, acc);
            acc = mac_f(v.m[i], v.x[i], acc);
            @(negedge clk);
            if (i < 3) begin
                chk($sformatf("%s beat%0d out_valid", v.name, i), out_valid_a, 0);
                chk($sformatf("%s beat%0d busy", v.name, i), busy_a, 1);
                if (v.gap > 0) begin
                    in_valid_a = 1'b0;
                    in_m_a     = W'($urandom);
                    in_x_a     = W'($urandom);
                    repeat (v.gap) @(negedge clk);
                    chk($sformatf("%s gap%0d out_valid", v.name, i), out_valid_a, 0);
                end
            end
        end
        // Keep offering junk while the result is held: none of it may be taken.
        in_m_a = W'($urandom);
        in_x_a = W'($urandom);
        chk({v.name, " latency out_valid"}, out_valid_a, 1);
        chk({v.name, " done in_ready"}, in_ready_a, 0);
        chk({v.name, " done busy"}, busy_a, 1);
        held = out_y_a;
        out_ready_a = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk($sformatf("%s hold%0d out_valid", v.name, h), out_valid_a, 1);
            chk($sformatf("%s hold%0d out_y", v.name, h), out_y_a, held);
        end
        out_ready_a = 1'b1;
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s scoreboard: got result %0d, expected none queued", v.name, out_y_a);
        end else begin
            exp_y = exp_q.pop_front();
            chk({v.name, " out_y"}, out_y_a, exp_y);
        end
        @(negedge clk);
        out_ready_a = 1'b0;
        in_valid_a  = 1'b0;
        chk({v.name, " post busy"}, busy_a, 0);
        chk({v.name, " post out_valid"}, out_valid_a, 0);
        chk({v.name, " post in_ready"}, in_ready_a, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic signed [W-1:0] acc;

        // name, m[3:0], x[3:0], bias, gap, hold, abort, exp_y
        tbl.push_back('{"basic",    {4{12'h100}}, {4{12'h100}}, 12'h080, 0, 0, 0, 12'h480}); // 4.5
        tbl.push_back('{"gaps",     {4{12'h100}}, {4{12'h100}}, 12'h080, 1, 5, 0, 12'h480});
        tbl.push_back('{"wrap",     {4{12'h200}}, {4{12'h200}}, 12'h000, 0, 1, 0, 12'h000});
        tbl.push_back('{"negative", {4{12'hF00}}, {4{12'h180}}, 12'hFC0, 0, 2, 0, 12'h9C0}); // -6.25
        tbl.push_back('{"rst_mid",  {4{12'h100}}, {4{12'h100}}, 12'h000, 0, 0, 2, 12'h400});
        for (int r = 0; r < 3; r++) begin
            v.name = $sformatf("rand%0d", r);
            for (int i = 0; i < 4; i++) begin
                v.m[i] = W'($urandom);
                v.x[i] = W'($urandom);
            end
            v.bias        = W'($urandom);
            v.gap         = $urandom_range(0, 2);
            v.hold        = $urandom_range(0, 3);
            v.abort_beats = 0;
            acc = v.bias;
            for (int i = 0; i < 4; i++) acc = mac_f(v.m[i], v.x[i], acc);
            v.exp_y = acc;
            tbl.push_back(v);
        end

        rst         = 1'b1;
        in_valid_a  = 1'b0; out_ready_a = 1'b0;
        in_m_a      = '0;   in_x_a      = '0;   in_bias_a = 12'h037;
        in_valid_b  = 1'b0; out_ready_b = 1'b0;
        in_m_b      = '0;   in_x_b      = '0;   in_bias_b = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready_a, 1);
        chk("reset out_valid", out_valid_a, 0);
        chk("reset busy", busy_a, 0);
        chk("reset out_y", out_y_a, 0);
        chk("reset mac_b=bias", mac_b_a, 12'sh037);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < tbl.size(); k++) run_vec(tbl[k]);
        chk("scoreboard drained", exp_q.size(), 0);

        // VEC_LEN=1: the single beat is both first and last.
        chk("len1 idle busy", busy_b, 0);
        in_valid_b = 1'b1;
        in_m_b     = 12'h100;
        in_x_b     = 12'h200;
        in_bias_b  = 12'h100;
        #1;
        chk("len1 mac_b=bias", mac_b_b, 12'sh100);
        @(negedge clk);
        in_valid_b = 1'b0;
        chk("len1 out_valid", out_valid_b, 1);
        chk("len1 in_ready", in_ready_b, 0);
        chk("len1 out_y", out_y_b, 12'sd768);
        out_ready_b = 1'b1;
        @(negedge clk);
        out_ready_b = 1'b0;
        chk("len1 post busy", busy_b, 0);
        chk("len1 post out_valid", out_valid_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
